router_stat_dump_ctrl: RTL and testbench

//  Sequences dumps of per-output router utilization counters (one per mesh-router direction) onto one shared stat stream.

---
 rtl/router_stat_dump_ctrl_if.sv | 40 ++++
 rtl/router_stat_dump_ctrl.sv | 153 +++++++++++++++
 tb/tb_router_stat_dump_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_stat_dump_ctrl_if.sv
`default_nettype none
//============================================================================
// Module      : router_stat_dump_ctrl_if
// Description : Trigger, snapshot and stat-stream signals of the router
//               stat dump controller.
// Revision    : 1.0
//============================================================================
interface router_stat_dump_ctrl_if #(
    parameter int DIMS_P           = 2,
    parameter int DROP_CTR_WIDTH_P = 16
);
    localparam int DIRS_LP = 1 + 2 * DIMS_P;

    logic [DIRS_LP*32-1:0]         util_i;
    logic                          print_stat_v_i;
    logic [31:0]                   print_stat_tag_i;
    logic [31:0]                   global_ctr_i;
    logic                          stat_v_o;
    logic                          stat_ready_i;
    logic [2:0]                    stat_dir_o;
    logic [31:0]                   stat_util_o;
    logic [31:0]                   stat_ctr_o;
    logic [31:0]                   stat_tag_o;
    logic                          stat_last_o;
    logic                          busy_o;
    logic [DROP_CTR_WIDTH_P-1:0]   dropped_o;

    modport master (
        output util_i, print_stat_v_i, print_stat_tag_i, global_ctr_i, stat_ready_i,
        input  stat_v_o, stat_dir_o, stat_util_o, stat_ctr_o, stat_tag_o,
               stat_last_o, busy_o, dropped_o
    );

    modport slave (
        input  util_i, print_stat_v_i, print_stat_tag_i, global_ctr_i, stat_ready_i,
        output stat_v_o, stat_dir_o, stat_util_o, stat_ctr_o, stat_tag_o,
               stat_last_o, busy_o, dropped_o
    );
endinterface
`default_nettype wire

// File: rtl/router_stat_dump_ctrl.sv
`default_nettype none
//============================================================================
// Module      : router_stat_dump_ctrl
// Description : Snapshots per-direction router utilization counters on a
//               trigger and streams one record per enabled direction.
// Revision    : 1.0
//============================================================================
module router_stat_dump_ctrl #(
    parameter int                DIMS_P            = 2,
    parameter logic [2*DIMS_P:0] DIR_MASK_P        = ~{{(2*DIMS_P){1'b0}}, 1'b1},
    parameter int                PERIOD_P          = 250,
    parameter bit                ENABLE_PERIODIC_P = 1'b0,
    parameter int                DROP_CTR_WIDTH_P  = 16
) (
    input  wire logic              clk_i,
    input  wire logic              reset_i,
    router_stat_dump_ctrl_if.slave stat_if
);
    localparam int DIRS_LP = 1 + 2 * DIMS_P;
    localparam int PCNT_W  = $clog2(PERIOD_P);

    function automatic logic [2:0] f_first_dir(input logic [DIRS_LP-1:0] mask);
        f_first_dir = '0;
        for (int d = DIRS_LP - 1; d >= 0; d--) begin
            if (mask[d]) f_first_dir = 3'(d);
        end
    endfunction

    function automatic logic [2:0] f_last_dir(input logic [DIRS_LP-1:0] mask);
        f_last_dir = '0;
        for (int d = 0; d < DIRS_LP; d++) begin
            if (mask[d]) f_last_dir = 3'(d);
        end
    endfunction

    localparam logic [2:0]        c_first_dir = f_first_dir(DIR_MASK_P);
    localparam logic [2:0]        c_last_dir  = f_last_dir(DIR_MASK_P);
    localparam logic [PCNT_W-1:0] c_pcnt_max  = PCNT_W'(PERIOD_P - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [31:0]                 r_snap [DIRS_LP];
    logic [31:0]                 r_ctr;
    logic [31:0]                 r_tag;
    logic [2:0]                  r_dir;
    logic                        r_armed;
    logic [PCNT_W-1:0]           r_pcnt;
    logic [29:0]                 r_sample_idx;
    logic [DROP_CTR_WIDTH_P-1:0] r_dropped;

    logic       w_emit;
    logic       w_pcnt_wrap;
    logic       w_tick;
    logic       w_trig;
    logic       w_accept;
    logic       w_hs;
    logic       w_last;
    logic       w_kstart;
    logic       w_kend;
    logic [2:0] w_next_dir;

    assign w_emit      = (r_state == ST_EMIT);
    assign w_pcnt_wrap = (r_pcnt == c_pcnt_max);
    assign w_tick      = ENABLE_PERIODIC_P && r_armed && w_pcnt_wrap;
    assign w_trig      = stat_if.print_stat_v_i || w_tick;
    assign w_last      = (r_dir == c_last_dir);
    assign w_hs        = w_emit && stat_if.stat_ready_i;
    assign w_kstart    = stat_if.print_stat_v_i && (stat_if.print_stat_tag_i[31:30] == 2'b10);
    assign w_kend      = stat_if.print_stat_v_i && (stat_if.print_stat_tag_i[31:30] == 2'b11);

    // Lowest enabled direction strictly above the current one.
    always_comb begin
        w_next_dir = r_dir;
        for (int d = DIRS_LP - 1; d >= 0; d--) begin
            if (DIR_MASK_P[d] && (3'(d) > r_dir)) w_next_dir = 3'(d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_state_next = ST_EMIT;
                    w_accept     = 1'b1;
                end
            end
            ST_EMIT: begin
                if (w_hs && w_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int d = 0; d < DIRS_LP; d++) r_snap[d] <= '0;
            r_ctr        <= '0;
            r_tag        <= '0;
            r_dir        <= '0;
            r_armed      <= 1'b0;
            r_pcnt       <= '0;
            r_sample_idx <= '0;
            r_dropped    <= '0;
        end else begin
            if (w_accept) begin
                for (int d = 0; d < DIRS_LP; d++) r_snap[d] <= stat_if.util_i[d*32 +: 32];
                r_ctr <= stat_if.global_ctr_i;
                // An explicit trigger wins the tag when it coincides with a tick.
                r_tag <= stat_if.print_stat_v_i ? stat_if.print_stat_tag_i
                                                : {2'b01, r_sample_idx};
                r_dir <= c_first_dir;
            end else if (w_hs && !w_last) begin
                r_dir <= w_next_dir;
            end

            if (w_emit && w_trig && (r_dropped != '1)) r_dropped <= r_dropped + 1'b1;

            if (w_tick) r_sample_idx <= r_sample_idx + 30'd1;

            if (w_kstart) begin
                r_armed <= 1'b1;
                r_pcnt  <= '0;
            end else if (w_kend) begin
                r_armed <= 1'b0;
                r_pcnt  <= '0;
            end else if (r_armed) begin
                r_pcnt <= w_pcnt_wrap ? '0 : r_pcnt + 1'b1;
            end
        end
    end

    assign stat_if.stat_v_o    = w_emit;
    assign stat_if.busy_o      = w_emit;
    assign stat_if.stat_dir_o  = r_dir;
    assign stat_if.stat_util_o = r_snap[r_dir];
    assign stat_if.stat_ctr_o  = r_ctr;
    assign stat_if.stat_tag_o  = r_tag;
    assign stat_if.stat_last_o = w_emit && w_last;
    assign stat_if.dropped_o   = r_dropped;
endmodule
`default_nettype wire

// File: tb/tb_router_stat_dump_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_router_stat_dump_ctrl
// Description : Scoreboard bench driving a 2-D default-mask instance with
//               periodic dumps and a 3-D sparse-mask instance in parallel.
// Revision    : 1.0
//============================================================================
module tb_router_stat_dump_ctrl;
    typedef struct packed {
        logic [2:0]  dir;
        logic [31:0] util;
        logic [31:0] ctr;
        logic [31:0] tag;
        logic        last;
    } rec_t;

    logic              clk;
    logic              rst;
    logic              pstat_v;
    logic              ready;
    logic [31:0]       ptag;
    logic [31:0]       gctr;
    logic [6:0][31:0]  util_pk;

    int checks   = 0;
    int failures = 0;
    int tmo      = 0;
    int sat_req  = 0;
    int sat_seen = 0;
    bit fin_req  = 1'b0;
    bit fin_done = 1'b0;

    router_stat_dump_ctrl_if #(.DIMS_P(2), .DROP_CTR_WIDTH_P(16)) if_a ();
    router_stat_dump_ctrl_if #(.DIMS_P(3), .DROP_CTR_WIDTH_P(16)) if_b ();

    assign if_a.util_i           = util_pk[4:0];
    assign if_a.print_stat_v_i   = pstat_v;
    assign if_a.print_stat_tag_i = ptag;
    assign if_a.global_ctr_i     = gctr;
    assign if_a.stat_ready_i     = ready;
    assign if_b.util_i           = util_pk;
    assign if_b.print_stat_v_i   = pstat_v;
    assign if_b.print_stat_tag_i = ptag;
    assign if_b.global_ctr_i     = gctr;
    assign if_b.stat_ready_i     = ready;

    router_stat_dump_ctrl #(
        .DIMS_P(2), .PERIOD_P(8), .ENABLE_PERIODIC_P(1'b1), .DROP_CTR_WIDTH_P(16)
    ) dut_a (.clk_i(clk), .reset_i(rst), .stat_if(if_a.slave));

    router_stat_dump_ctrl #(
        .DIMS_P(3), .DIR_MASK_P(7'b0100100), .PERIOD_P(250),
        .ENABLE_PERIODIC_P(1'b0), .DROP_CTR_WIDTH_P(16)
    ) dut_b (.clk_i(clk), .reset_i(rst), .stat_if(if_b.slave));

    logic        m_v    [2];
    logic        m_busy [2];
    logic        m_lst  [2];
    logic [2:0]  m_dir  [2];
    logic [31:0] m_util [2];
    logic [31:0] m_ctr  [2];
    logic [31:0] m_tag  [2];
    logic [15:0] m_drp  [2];

    assign m_v[0] = if_a.stat_v_o;    assign m_v[1] = if_b.stat_v_o;
    assign m_busy[0] = if_a.busy_o;   assign m_busy[1] = if_b.busy_o;
    assign m_lst[0] = if_a.stat_last_o; assign m_lst[1] = if_b.stat_last_o;
    assign m_dir[0] = if_a.stat_dir_o;  assign m_dir[1] = if_b.stat_dir_o;
    assign m_util[0] = if_a.stat_util_o; assign m_util[1] = if_b.stat_util_o;
    assign m_ctr[0] = if_a.stat_ctr_o;  assign m_ctr[1] = if_b.stat_ctr_o;
    assign m_tag[0] = if_a.stat_tag_o;  assign m_tag[1] = if_b.stat_tag_o;
    assign m_drp[0] = if_a.dropped_o;   assign m_drp[1] = if_b.dropped_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) gctr <= rst ? 32'h1000 : gctr + 32'd1;

    // ------------------------------------------------------------------
    // Reference model: per-instance expected records and bookkeeping
    // ------------------------------------------------------------------
    rec_t q0[$];
    rec_t q1[$];

    bit          r_busy  [2];
    int          r_rem   [2];
    bit          r_armed [2];
    int          r_pcnt  [2];
    logic [29:0] r_idx   [2];
    logic [15:0] r_drop  [2];

    function automatic logic [6:0] cfg_mask(input int g);
        return (g == 0) ? 7'b0011110 : 7'b0100100;
    endfunction
    function automatic bit cfg_en(input int g);
        return (g == 0);
    endfunction
    function automatic int cfg_per(input int g);
        return (g == 0) ? 8 : 250;
    endfunction
    function automatic int qsize(input int g);
        return (g == 0) ? q0.size() : q1.size();
    endfunction
    function automatic rec_t qfront(input int g);
        return (g == 0) ? q0[0] : q1[0];
    endfunction
    task automatic qpush(input int g, input rec_t r);
        if (g == 0) q0.push_back(r); else q1.push_back(r);
    endtask
    task automatic qpop(input int g);
        if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            logic        tick;
            logic        trig;
            logic [31:0] tg;
            logic [6:0]  mask;
            int          hi;
            int          cnt;
            rec_t        rec;
            if (rst) begin
                r_busy[g] = 1'b0; r_rem[g] = 0; r_armed[g] = 1'b0;
                r_pcnt[g] = 0; r_idx[g] = '0; r_drop[g] = '0;
                if (g == 0) q0.delete(); else q1.delete();
            end else begin
                mask = cfg_mask(g);
                tick = cfg_en(g) && r_armed[g] && (r_pcnt[g] == cfg_per(g) - 1);
                trig = pstat_v || tick;
                tg   = pstat_v ? ptag : {2'b01, r_idx[g]};
                if (r_busy[g]) begin
                    if (trig && r_drop[g] != 16'hFFFF) r_drop[g] = r_drop[g] + 16'd1;
                    if (ready) begin
                        r_rem[g]--;
                        if (r_rem[g] == 0) r_busy[g] = 1'b0;
                    end
                end else if (trig) begin
                    hi = 0;
                    cnt = 0;
                    for (int d = 0; d < 7; d++) if (mask[d]) hi = d;
                    for (int d = 0; d < 7; d++) begin
                        if (mask[d]) begin
                            rec.dir  = 3'(d);
                            rec.util = util_pk[d];
                            rec.ctr  = gctr;
                            rec.tag  = tg;
                            rec.last = (d == hi);
                            qpush(g, rec);
                            cnt++;
                        end
                    end
                    r_busy[g] = 1'b1;
                    r_rem[g]  = cnt;
                end
                if (tick) r_idx[g] = r_idx[g] + 30'd1;
                if (pstat_v && ptag[31:30] == 2'b10) begin
                    r_armed[g] = 1'b1; r_pcnt[g] = 0;
                end else if (pstat_v && ptag[31:30] == 2'b11) begin
                    r_armed[g] = 1'b0; r_pcnt[g] = 0;
                end else if (r_armed[g]) begin
                    r_pcnt[g] = (r_pcnt[g] == cfg_per(g) - 1) ? 0 : r_pcnt[g] + 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: all comparisons happen here, on the falling edge
    // ------------------------------------------------------------------
    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            rec_t e;
            check(m_v[g] === r_busy[g], "stat_v",
                  $sformatf("dut%0d got %b want %b t=%0t", g, m_v[g], r_busy[g], $time));
            check(m_busy[g] === r_busy[g], "busy",
                  $sformatf("dut%0d got %b want %b", g, m_busy[g], r_busy[g]));
            check(m_drp[g] === r_drop[g], "dropped",
                  $sformatf("dut%0d got %h want %h", g, m_drp[g], r_drop[g]));
            if (m_v[g] === 1'b1) begin
                check(qsize(g) != 0, "rec_expected",
                      $sformatf("dut%0d got record dir %0d want none", g, m_dir[g]));
                if (qsize(g) != 0) begin
                    e = qfront(g);
                    check(m_dir[g] === e.dir && m_util[g] === e.util && m_ctr[g] === e.ctr &&
                          m_tag[g] === e.tag && m_lst[g] === e.last, "record",
                          $sformatf("dut%0d got dir=%0d util=%h ctr=%h tag=%h last=%b want dir=%0d util=%h ctr=%h tag=%h last=%b",
                                    g, m_dir[g], m_util[g], m_ctr[g], m_tag[g], m_lst[g],
                                    e.dir, e.util, e.ctr, e.tag, e.last));
                    if (ready) qpop(g);
                end
            end
        end
        if (sat_req != sat_seen) begin
            check(m_drp[0] === 16'hFFFF && m_drp[1] === 16'hFFFF, "drop_saturate",
                  $sformatf("got %h/%h want ffff/ffff", m_drp[0], m_drp[1]));
            sat_seen = sat_req;
        end
        if (fin_req && !fin_done) begin
            check(q0.size() == 0, "pending_a", $sformatf("got %0d left want 0", q0.size()));
            check(q1.size() == 0, "pending_b", $sformatf("got %0d left want 0", q1.size()));
            check(tmo == 0, "idle_timeout", $sformatf("got %0d timeouts want 0", tmo));
            fin_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] tag);
        pstat_v = 1'b1;
        ptag    = tag;
        cyc();
        pstat_v = 1'b0;
    endtask

    task automatic wait_idle();
        ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!r_busy[0] && !r_busy[1] && m_v[0] !== 1'b1 && m_v[1] !== 1'b1) return;
            cyc();
        end
        tmo++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        pstat_v = 1'b0;
        ptag    = '0;
        ready   = 1'b1;
        for (int d = 0; d < 7; d++) util_pk[d] = 32'(d * 10);
        do_reset();

        // Basic dump with ready held high
        pulse(32'd5);
        wait_idle();
        cyc();

        // Back-pressure on the second record while live counters move
        pulse(32'd6);
        cyc();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int d = 0; d < 7; d++) util_pk[d] = $urandom;
            cyc();
        end
        wait_idle();

        // Triggers during a dump are dropped; saturate the drop counter
        pulse(32'd7);
        pstat_v = 1'b1;
        ready   = 1'b0;
        cyc();
        pstat_v = 1'b0;
        ready   = 1'b1;
        wait_idle();
        ready   = 1'b0;
        pstat_v = 1'b1;
        repeat (65540) cyc();
        sat_req++;
        pstat_v = 1'b0;
        cyc();
        wait_idle();
        do_reset();

        // Kernel start arms periodic sampling; kernel end stops it
        pulse(32'h8000_0000);
        repeat (30) cyc();
        pulse(32'hC000_0000);
        wait_idle();
        repeat (20) cyc();

        // Randomized triggers, tags, ready and counters
        for (int i = 0; i < 1500; i++) begin
            pstat_v = ($urandom_range(0, 7) == 0);
            ptag    = $urandom;
            ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0)
                for (int d = 0; d < 7; d++) util_pk[d] = $urandom;
            cyc();
        end
        pstat_v = 1'b0;
        wait_idle();
        cyc();

        // Reset in the middle of a dump
        pulse(32'd9);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (3) cyc();

        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_done; i++) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
